// File: rtl/au_pkg.sv
// Shared definitions for the au_* Gray-code blocks: architecture codes and
// width-generic Gray/binary conversion helpers.
package au_pkg;

    localparam int AU_ARCH_BIN  = 0;
    localparam int AU_ARCH_GRAY = 1;
    localparam int AU_MAXW      = 64;

    typedef logic [AU_MAXW-1:0] au_word_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_LD   = 2'd2,
        OP_STEP = 2'd3
    } au_op_e;

    function automatic au_word_t au_mask(input int w);
        if (w >= AU_MAXW)
            return '1;
        return (au_word_t'(1) << w) - au_word_t'(1);
    endfunction

    function automatic au_word_t bin2gray(input au_word_t x, input int w);
        au_word_t xm;
        xm = x & au_mask(w);
        return xm ^ (xm >> 1);
    endfunction

    // Prefix XOR from the MSB down, done as log2(AU_MAXW) shift-xor stages.
    function automatic au_word_t gray2bin(input au_word_t x, input int w);
        au_word_t r;
        r = x & au_mask(w);
        for (int s = 1; s < AU_MAXW; s = s * 2)
            r = r ^ (r >> s);
        return r;
    endfunction

endpackage

// File: rtl/au_bin2gray.sv
// Combinational binary-to-Gray converter.
module au_bin2gray #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    assign g = b ^ (b >> 1);

endmodule

// File: rtl/au_gray_cnt.sv
// Up/down counter with registered Gray and binary images of the same state.
// ARCH selects how the next state is formed; both give cycle-identical outputs.
module au_gray_cnt
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             dn,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b,
    output logic             wrp
);

    if (WIDTH < 1 || WIDTH > AU_MAXW ||
        (ARCH != AU_ARCH_BIN && ARCH != AU_ARCH_GRAY) ||
        (WRAP != 0 && WRAP != 1)) begin : g_bad_param
        $fatal(1, "au_gray_cnt: bad parameters WIDTH=%0d ARCH=%0d WRAP=%0d",
               WIDTH, ARCH, WRAP);
    end

    localparam logic [WIDTH-1:0] ALL1    = '1;
    localparam logic [WIDTH-1:0] TOP_BIT = ~(ALL1 >> 1);

    logic [WIDTH-1:0] g_q, b_q;
    logic             wrp_q;
    logic [WIDTH-1:0] ld_g;
    logic [WIDTH-1:0] step_b, step_g;
    logic             at_edge, blocked;
    au_op_e           op;

    always_comb begin
        op = OP_HOLD;
        if (clr)
            op = OP_CLR;
        else if (ld)
            op = OP_LD;
        else if (en)
            op = OP_STEP;
    end

    assign at_edge = dn ? (b_q == '0) : (b_q == ALL1);
    assign blocked = (WRAP == 0) && at_edge;

    au_bin2gray #(.WIDTH(WIDTH)) u_ld_gray (
        .b (d),
        .g (ld_g)
    );

    if (ARCH == AU_ARCH_BIN) begin : g_arch_bin
        assign step_b = dn ? (b_q - WIDTH'(1)) : (b_q + WIDTH'(1));

        au_bin2gray #(.WIDTH(WIDTH)) u_step_gray (
            .b (step_b),
            .g (step_g)
        );
    end else begin : g_arch_gray
        logic             par;
        logic [WIDTH-1:0] low, flip;

        // Even parity steps up by flipping bit 0; odd parity flips the bit
        // left of the lowest set bit (mirrored for down). The MSB saturates
        // that rule so 100..0 wraps to 0 and 0 wraps down to 100..0.
        always_comb begin
            par  = ^g_q;
            low  = g_q & (~g_q + WIDTH'(1));
            flip = WIDTH'(1);
            if (par != dn) begin
                if (g_q == '0 || low == TOP_BIT)
                    flip = TOP_BIT;
                else
                    flip = low << 1;
            end
        end

        assign step_g = g_q ^ flip;
        assign step_b = WIDTH'(gray2bin(AU_MAXW'(step_g), WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q   <= '0;
            b_q   <= '0;
            wrp_q <= 1'b0;
        end else begin
            case (op)
                OP_CLR: begin
                    g_q   <= '0;
                    b_q   <= '0;
                    wrp_q <= 1'b0;
                end
                OP_LD: begin
                    g_q   <= ld_g;
                    b_q   <= d;
                    wrp_q <= 1'b0;
                end
                OP_STEP: begin
                    wrp_q <= at_edge;
                    if (!blocked) begin
                        g_q <= step_g;
                        b_q <= step_b;
                    end
                end
                default: wrp_q <= 1'b0;
            endcase
        end
    end

    assign g   = g_q;
    assign b   = b_q;
    assign wrp = wrp_q;

endmodule

// File: tb/tb_au_gray_cnt.sv
// Scoreboard bench: eight counter instances (WIDTH 1/4/9, both ARCH, both WRAP)
// share one stimulus bus; expectations are queued and checked by a monitor.
module tb_au_gray_cnt;

    localparam int NU = 8;
    localparam int WS [NU] = '{4, 4, 4, 4, 1, 1, 9, 9};
    localparam int AS [NU] = '{0, 1, 0, 1, 0, 1, 0, 1};
    localparam int RS [NU] = '{1, 1, 0, 0, 1, 1, 1, 1};

    logic       clk = 1'b0;
    logic       rst, clr, ld, en, dn;
    logic [8:0] d;
    logic [8:0] g_o [NU];
    logic [8:0] b_o [NU];
    logic       wrp_o [NU];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NU; i++) begin : g_u
        localparam int W = WS[i];
        logic [W-1:0] g, b;
        logic         wrp;

        au_gray_cnt #(.WIDTH(W), .ARCH(AS[i]), .WRAP(RS[i])) u_dut (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .ld  (ld),
            .d   (d[W-1:0]),
            .en  (en),
            .dn  (dn),
            .g   (g),
            .b   (b),
            .wrp (wrp)
        );

        assign g_o[i]   = 9'(g);
        assign b_o[i]   = 9'(b);
        assign wrp_o[i] = wrp;
    end

    typedef struct {
        int         cyc;
        int         tst;
        int         u;
        logic [8:0] g;
        logic [8:0] b;
        logic       wrp;
        logic       step;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         tst = 0;
    logic       cur_step = 1'b0;
    logic [8:0] gprev [NU];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] g2b(input logic [8:0] x);
        logic [8:0] r;
        r[8] = x[8];
        for (int i = 7; i >= 0; i--)
            r[i] = r[i+1] ^ x[i];
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || g_o[e.u] !== e.g || b_o[e.u] !== e.b || wrp_o[e.u] !== e.wrp) begin
                errors++;
                $display("FAIL sb t%0d u%0d cyc%0d: got g=%h b=%h wrp=%b, want g=%h b=%h wrp=%b (due cyc%0d)",
                         e.tst, e.u, cyc, g_o[e.u], b_o[e.u], wrp_o[e.u], e.g, e.b, e.wrp, e.cyc);
            end
            checks++;
            if (g2b(g_o[e.u]) !== b_o[e.u]) begin
                errors++;
                $display("FAIL g2b t%0d u%0d cyc%0d: b=%h, want gray2bin(g)=%h",
                         e.tst, e.u, cyc, b_o[e.u], g2b(g_o[e.u]));
            end
            if (e.step) begin
                checks++;
                if ($countones(g_o[e.u] ^ gprev[e.u]) > 1) begin
                    errors++;
                    $display("FAIL onebit t%0d u%0d cyc%0d: g %h -> %h, want <=1 bit change",
                             e.tst, e.u, cyc, gprev[e.u], g_o[e.u]);
                end
            end
            gprev[e.u] = g_o[e.u];
            if (e.u % 2 == 0) begin
                checks++;
                if ({g_o[e.u], b_o[e.u], wrp_o[e.u]} !== {g_o[e.u+1], b_o[e.u+1], wrp_o[e.u+1]}) begin
                    errors++;
                    $display("FAIL arch t%0d u%0d cyc%0d: arch1 g=%h b=%h wrp=%b, want arch0 g=%h b=%h wrp=%b",
                             e.tst, e.u, cyc, g_o[e.u+1], b_o[e.u+1], wrp_o[e.u+1],
                             g_o[e.u], b_o[e.u], wrp_o[e.u]);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic c, input logic l, input int dv,
                         input logic e, input logic m);
        @(negedge clk);
        #1;
        rst = r; clr = c; ld = l; d = 9'(dv); en = e; dn = m;
        cur_step = !r && !c && !l && e;
    endtask

    task automatic push(input int u, input int gv, input int bv, input logic w);
        exp_t x;
        x.cyc = cyc + 1; x.tst = tst; x.u = u;
        x.g = 9'(gv); x.b = 9'(bv); x.wrp = w; x.step = cur_step;
        q.push_back(x);
    endtask

    // Expectations for the WIDTH=4 wrapping pair and the saturating pair.
    task automatic pw(input int gv, input int bv, input logic w);
        push(0, gv, bv, w);
        push(1, gv, bv, w);
    endtask

    task automatic pn(input int gv, input int bv, input logic w);
        push(2, gv, bv, w);
        push(3, gv, bv, w);
    endtask

    initial begin : stim
        int gl [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        int b2w [6] = '{4, 3, 2, 1, 0, 15};
        int g2w [6] = '{6, 2, 3, 1, 0, 8};
        int b2n [6] = '{4, 3, 2, 1, 0, 0};
        int g2n [6] = '{6, 2, 3, 1, 0, 0};
        int b3w [3] = '{15, 0, 1};
        int g3w [3] = '{8, 0, 1};
        int mb [NU];
        rst = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0; dn = 1'b0; d = '0;

        // 1: reset then count up through the wrap
        tst = 1;
        drive(1, 0, 0, 0, 0, 0);
        pw(0, 0, 0); pn(0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            pw(gl[k % 16], k % 16, k == 16);
            pn((k < 16) ? gl[k] : 8, (k < 16) ? k : 15, k == 16);
        end

        // 2: load 5 then count down through 0
        tst = 2;
        drive(0, 0, 1, 5, 0, 0);
        pw(7, 5, 0); pn(7, 5, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 1, 1);
            pw(g2w[k], b2w[k], k == 5);
            pn(g2n[k], b2n[k], k == 5);
        end

        // 3: up into the top boundary, then down from 0
        tst = 3;
        drive(0, 0, 1, 14, 0, 0);
        pw(9, 14, 0); pn(9, 14, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            pw(g3w[k], b3w[k], k == 1);
            pn(8, 15, k != 0);
        end
        drive(0, 1, 0, 0, 0, 0);
        pw(0, 0, 0); pn(0, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        pw(8, 15, 1); pn(0, 0, 1);
        drive(0, 0, 0, 0, 1, 1);
        pw(9, 14, 0); pn(0, 0, 1);

        // 4: control priority
        tst = 4;
        drive(1, 1, 1, 9, 1, 0);
        pw(0, 0, 0); pn(0, 0, 0);
        drive(0, 1, 1, 9, 0, 0);
        pw(0, 0, 0); pn(0, 0, 0);
        drive(0, 0, 1, 9, 1, 0);
        pw(13, 9, 0); pn(13, 9, 0);

        // 6: reset mid-count at b=A, then resume from 0
        tst = 6;
        drive(0, 0, 1, 8, 0, 0);
        pw(12, 8, 0); pn(12, 8, 0);
        drive(0, 0, 0, 0, 1, 0);
        pw(13, 9, 0); pn(13, 9, 0);
        drive(0, 0, 0, 0, 1, 0);
        pw(15, 10, 0); pn(15, 10, 0);
        drive(1, 0, 0, 0, 1, 0);
        pw(0, 0, 0); pn(0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        pw(1, 1, 0); pn(1, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        pw(3, 2, 0); pn(3, 2, 0);

        // 5: random control mix against a modulo / saturating model, all widths
        tst = 5;
        drive(1, 0, 0, 0, 0, 0);
        for (int u = 0; u < NU; u++) begin
            mb[u] = 0;
            push(u, 0, 0, 0);
        end
        for (int n = 0; n < 10000; n++) begin
            logic r, c, l, e, m;
            int   dv, sel;
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 31) == 0);
            l   = ($urandom_range(0, 15) == 0);
            e   = ($urandom_range(0, 3) != 0);
            m   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            dv  = (sel == 0) ? 0 : (sel == 1) ? 511 : int'($urandom_range(0, 511));
            drive(r, c, l, dv, e, m);
            for (int u = 0; u < NU; u++) begin
                int   mx;
                logic w;
                mx = (1 << WS[u]) - 1;
                w  = 1'b0;
                if (r || c) begin
                    mb[u] = 0;
                end else if (l) begin
                    mb[u] = dv & mx;
                end else if (e) begin
                    if (!m) begin
                        if (mb[u] == mx) begin
                            w = 1'b1;
                            if (RS[u] == 1) mb[u] = 0;
                        end else begin
                            mb[u] = mb[u] + 1;
                        end
                    end else begin
                        if (mb[u] == 0) begin
                            w = 1'b1;
                            if (RS[u] == 1) mb[u] = mx;
                        end else begin
                            mb[u] = mb[u] - 1;
                        end
                    end
                end
                push(u, mb[u] ^ (mb[u] >> 1), mb[u], w);
            end
        end

        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
